addsub_pipe: RTL and testbench
==============================

Name: addsub_pipe

Overview:
- Parametrised, pipelined carry-select adder/subtractor for the eBPF core ALU datapath.
- Generalises the fixed 32-bit single-cycle carry-select adder:
  - configurable width and segment size;
  - one segment resolved per pipeline stage, with registered carry between stages;
  - valid/ready handshake with backpressure;
  - eBPF ALU32 mode;
  - carry, overflow, zero and negative flags;
  - tag passthrough.
- Sits between the decode/operand-fetch stage and the writeback stage.

Parameters:
- WIDTH, 64, operand/result width; must be a multiple of SEG_W; if WIDTH > 32, 32 must also be a multiple of SEG_W.
- SEG_W, 16, segment width; one segment is computed per pipeline stage.
- TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation present on the input.
- in_ready  out  1  block can accept an operation this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  1 = A-B, 0 = A+B.
- in_alu32  in  1  1 = 32-bit op; result is zero-extended.
- in_tag  in  TAG_W  sideband tag, returned unchanged with the result.
- out_valid  out  1  result present on the output.
- out_ready  in  1  downstream accepts the result.
- out_result  out  WIDTH  sum or difference.
- out_carry  out  1  carry-out of the adder (for subtract: 1 = no borrow).
- out_ovf  out  1  signed overflow.
- out_zero  out  1  result == 0 within the active width.
- out_neg  out  1  MSB of the active width.
- out_tag  out  TAG_W  tag of the returned operation.

Behaviour:
- NSEG = WIDTH/SEG_W; latency = NSEG cycles from input handshake to out_valid, independent of in_alu32.
- Global stage enable: en = ~out_valid | out_ready; in_ready = en.
  - Bubbles are not compressed.
  - When en = 0, every pipeline register holds its value.
- Stage 0:
  - Registers b' = in_sub ? ~in_b : in_b.
  - cin = in_sub.
  - Registers the mode bits and the tag.
  - Computes segment 0.
- Stage k, for k = 1..NSEG-1:
  - Two SEG_W adders on segment k, one with cin 0 and one with cin 1.
  - The registered carry from stage k-1 selects the result.
  - Unprocessed upper operand segments travel in skew registers.
  - Completed lower result segments travel in deskew registers.
- ALU32 (in_alu32 = 1):
  - At segment index 32/SEG_W the carry chain is forced to 0.
  - Bits [WIDTH-1:32] of out_result are 0.
  - Flags use bit 31: carry = carry out of bit 31; ovf = (a31 == b'31) & (r31 != a31); zero over [31:0]; neg = r31.
  - If WIDTH == 32, in_alu32 is ignored.
- 64-bit mode:
  - Flags use bit WIDTH-1 analogously.
  - carry = carry out of the top segment.
- Output registers:
  - The last stage drives out_* registered.
  - out_valid stays high, with stable data, until out_ready is sampled high.
- Reset (rst_n = 0, asynchronous):
  - All stage valid bits, out_valid, out_result, flags and out_tag clear to 0.
  - In-flight operations are discarded.
  - in_ready = 1 from the first clock after reset release.
- Simultaneous output accept and input accept in the same cycle: the pipe advances one stage with no loss or duplication.
- Wrap-around is modulo 2^WIDTH, or modulo 2^32 in ALU32 mode; there is no exception.

Optional Feature:
- ADDSUB_SAT_EN defined:
  - Adds input port in_sat (1 bit), registered with the operation.
  - When in_sat = 1 and ovf = 1, out_result is saturated to the signed max (0111..1) or min (1000..0) of the active width. The choice is taken from the sign of operand A.
  - ALU32 saturation is zero-extended.
  - out_ovf still reports 1.
- Not defined:
  - No in_sat port.
  - Result always wraps.
  - Logic identical otherwise.

Decomposition:
- Package addsub_pkg:
  - typedef addsub_op_t struct {sub, alu32, sat};
  - typedef addsub_flags_t struct {carry, ovf, zero, neg};
  - localparam ALU32_W = 32.
- Sub-module csel_segment:
  - Parametrised SEG_W carry-select cell: dual adders with cin 0/1, plus a mux on carry-in.
  - Outputs sum and cout.
  - Instantiated once per stage via generate.

Test Plan (WIDTH=64, SEG_W=16, latency 4):
- Carry across 32: add 0x00000000_FFFFFFFF + 1 -> 0x00000001_00000000; carry=0, ovf=0, zero=0; out_valid exactly 4 cycles after the handshake.
- Subtract below zero: sub 0 - 1 -> 0xFFFFFFFF_FFFFFFFF; carry=0, neg=1, ovf=0.
- ALU32 wrap: alu32 add 0xFFFFFFFF_FFFFFFFF + 1 -> 0x0; zero=1, carry=1, upper 32 bits 0.
- Signed overflow: add 0x7FFFFFFF_FFFFFFFF + 1 -> 0x80000000_00000000, ovf=1. With ADDSUB_SAT_EN and in_sat=1 -> 0x7FFFFFFF_FFFFFFFF, ovf=1.
- Backpressure: 8 back-to-back random ops, tags 0..7, out_ready toggled pseudo-randomly -> results match the model in order; each tag appears exactly once; outputs are stable while stalled.
- Reset mid-flight: 3 ops in the pipe, rst_n pulsed low asynchronously mid-cycle -> out_valid=0 immediately; no stale result after release; the next op returns correctly after 4 cycles.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and constants for the pipelined carry-select adder/subtractor.
package addsub_pkg;

  localparam int ALU32_W = 32;

  typedef struct packed {
    logic sub;
    logic alu32;
    logic sat;
  } addsub_op_t;

  typedef struct packed {
    logic carry;
    logic ovf;
    logic zero;
    logic neg;
  } addsub_flags_t;

endpackage

// File: rtl/addsub_pipe_csel_segment.sv
// One carry-select cell: both carry-in hypotheses are summed in parallel and
// the real carry-in picks one.
module csel_segment
  import addsub_pkg::*;
#(
  parameter int SEG_W = 16
) (
  input  logic [SEG_W-1:0] a_i,
  input  logic [SEG_W-1:0] b_i,
  input  logic             cin_i,
  output logic [SEG_W-1:0] sum_o,
  output logic             cout_o
);

  logic [SEG_W:0] sum0;
  logic [SEG_W:0] sum1;

  assign sum0 = {1'b0, a_i} + {1'b0, b_i};
  assign sum1 = {1'b0, a_i} + {1'b0, b_i} + {{SEG_W{1'b0}}, 1'b1};
  assign {cout_o, sum_o} = cin_i ? sum1 : sum0;

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined carry-select add/sub, one SEG_W segment resolved per stage.
// Optional saturation on signed overflow when ADDSUB_SAT_EN is defined.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SEG_W = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_alu32,
  input  logic [TAG_W-1:0] in_tag,
`ifdef ADDSUB_SAT_EN
  input  logic             in_sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg,
  output logic [TAG_W-1:0] out_tag
);

  localparam int   NSEG  = WIDTH / SEG_W;
  localparam logic HAS32 = (WIDTH > ALU32_W);
  localparam int   A_SEG = HAS32 ? ALU32_W / SEG_W : NSEG;
  localparam int   A_MSB = HAS32 ? ALU32_W - 1 : WIDTH - 1;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. The whole pipe advances together on en, so in_ready is en and
  // a stalled output freezes every stage (bubbles are kept, not squeezed).
  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // Rank k holds an operation whose segments below k are already resolved.
  logic [NSEG-1:0]  vld_q;
  logic [WIDTH-1:0] a_q   [NSEG];
  logic [WIDTH-1:0] b_q   [NSEG];
  logic [WIDTH-1:0] r_q   [NSEG];
  logic             cy_q  [NSEG];
  logic             c31_q [NSEG];
  addsub_op_t       op_q  [NSEG];
  logic [TAG_W-1:0] tag_q [NSEG];

  logic [SEG_W-1:0] sum_w  [NSEG];
  logic             cout_w [NSEG];
  logic             cin_w  [NSEG];
  logic [WIDTH-1:0] rn_w   [NSEG];
  logic             c31n_w [NSEG];

  addsub_op_t op_in;
  logic [WIDTH-1:0] b_in;

  assign b_in  = in_sub ? ~in_b : in_b;
  assign op_in.sub   = in_sub;
  assign op_in.alu32 = in_alu32 & HAS32;
`ifdef ADDSUB_SAT_EN
  assign op_in.sat   = in_sat;
`else
  assign op_in.sat   = 1'b0;
`endif

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    if (k == 0) begin : g_first
      assign cin_w[k] = op_q[k].sub;
    end else if (k == A_SEG) begin : g_cut32
      assign cin_w[k] = cy_q[k] & ~op_q[k].alu32;
    end else begin : g_mid
      assign cin_w[k] = cy_q[k];
    end

    csel_segment #(.SEG_W(SEG_W)) u_seg (
      .a_i    (a_q[k][k*SEG_W +: SEG_W]),
      .b_i    (b_q[k][k*SEG_W +: SEG_W]),
      .cin_i  (cin_w[k]),
      .sum_o  (sum_w[k]),
      .cout_o (cout_w[k])
    );
  end

  always_comb begin
    for (int k = 0; k < NSEG; k++) begin
      rn_w[k] = r_q[k];
      rn_w[k][k*SEG_W +: SEG_W] = sum_w[k];
      c31n_w[k] = (k == A_SEG - 1) ? cout_w[k] : c31_q[k];
    end
  end

  logic [WIDTH-1:0] fin;
  logic [WIDTH-1:0] a_f;
  logic [WIDTH-1:0] b_f;
  logic [WIDTH-1:0] res32;
  logic [WIDTH-1:0] sat_v;
  logic [WIDTH-1:0] result_d;
  addsub_flags_t    flags_d;
  addsub_op_t       op_f;

  assign fin  = rn_w[NSEG-1];
  assign a_f  = a_q[NSEG-1];
  assign b_f  = b_q[NSEG-1];
  assign op_f = op_q[NSEG-1];

  // Flags are taken from the wrapped sum; saturation only replaces the result.
  always_comb begin
    res32 = '0;
    res32[A_MSB:0] = fin[A_MSB:0];
    sat_v = '0;
    if (op_f.alu32) begin
      result_d      = res32;
      flags_d.carry = c31n_w[NSEG-1];
      flags_d.ovf   = (a_f[A_MSB] == b_f[A_MSB]) & (fin[A_MSB] != a_f[A_MSB]);
      flags_d.zero  = (fin[A_MSB:0] == '0);
      flags_d.neg   = fin[A_MSB];
      sat_v[A_MSB]  = a_f[A_MSB];
      sat_v[A_MSB-1:0] = {A_MSB{~a_f[A_MSB]}};
    end else begin
      result_d      = fin;
      flags_d.carry = cout_w[NSEG-1];
      flags_d.ovf   = (a_f[WIDTH-1] == b_f[WIDTH-1]) & (fin[WIDTH-1] != a_f[WIDTH-1]);
      flags_d.zero  = (fin == '0);
      flags_d.neg   = fin[WIDTH-1];
      sat_v[WIDTH-1]   = a_f[WIDTH-1];
      sat_v[WIDTH-2:0] = {(WIDTH-1){~a_f[WIDTH-1]}};
    end
    if (op_f.sat & flags_d.ovf) begin
      result_d = sat_v;
    end
  end

  logic             out_valid_q;
  logic [WIDTH-1:0] out_result_q;
  addsub_flags_t    out_flags_q;
  logic [TAG_W-1:0] out_tag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q        <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
      out_tag_q    <= '0;
      for (int k = 0; k < NSEG; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        r_q[k]   <= '0;
        cy_q[k]  <= 1'b0;
        c31_q[k] <= 1'b0;
        op_q[k]  <= '0;
        tag_q[k] <= '0;
      end
    end else if (en) begin
      vld_q[0] <= in_valid;
      a_q[0]   <= in_a;
      b_q[0]   <= b_in;
      r_q[0]   <= '0;
      cy_q[0]  <= 1'b0;
      c31_q[0] <= 1'b0;
      op_q[0]  <= op_in;
      tag_q[0] <= in_tag;
      for (int k = 1; k < NSEG; k++) begin
        vld_q[k] <= vld_q[k-1];
        a_q[k]   <= a_q[k-1];
        b_q[k]   <= b_q[k-1];
        r_q[k]   <= rn_w[k-1];
        cy_q[k]  <= cout_w[k-1];
        c31_q[k] <= c31n_w[k-1];
        op_q[k]  <= op_q[k-1];
        tag_q[k] <= tag_q[k-1];
      end
      out_valid_q  <= vld_q[NSEG-1];
      out_result_q <= result_d;
      out_flags_q  <= flags_d;
      out_tag_q    <= tag_q[NSEG-1];
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_carry  = out_flags_q.carry;
  assign out_ovf    = out_flags_q.ovf;
  assign out_zero   = out_flags_q.zero;
  assign out_neg    = out_flags_q.neg;
  assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe (WIDTH=64, SEG_W=16); build with
// ADDSUB_SAT_EN defined to exercise saturation.
module tb_addsub_pipe;

  localparam int W   = 64;
  localparam int TW  = 4;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          in_sub = 1'b0;
  logic          in_alu32 = 1'b0;
  logic [TW-1:0] in_tag = '0;
  logic          in_sat = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_result;
  logic          out_carry, out_ovf, out_zero, out_neg;
  logic [TW-1:0] out_tag;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W+TW:0] exp_q[$];

  logic [W-1:0]  r_res;
  logic          r_c, r_v, r_z, r_n;
  logic [TW-1:0] r_tag;
  int            r_lat;

  addsub_pipe #(.WIDTH(W), .SEG_W(16), .TAG_W(TW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sub     (in_sub),
    .in_alu32   (in_alu32),
    .in_tag     (in_tag),
`ifdef ADDSUB_SAT_EN
    .in_sat     (in_sat),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_ovf    (out_ovf),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .out_tag    (out_tag)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: plain wide arithmetic, result {tag, carry, result}
  function automatic logic [W+TW:0] model(input logic [W-1:0] a, b, input logic sub, alu32,
                                           input logic [TW-1:0] tag);
    logic [W-1:0] bp;
    logic [W:0]   s;
    logic [32:0]  s32;
    bp = sub ? ~b : b;
    if (alu32) begin
      s32 = {1'b0, a[31:0]} + {1'b0, bp[31:0]} + {32'd0, sub};
      return {tag, s32[32], 32'd0, s32[31:0]};
    end
    s = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, sub};
    return {tag, s[W], s[W-1:0]};
  endfunction

  // Driver tasks
  task automatic drive_op(input logic [W-1:0] a, b, input logic sub, alu32, sat,
                          input logic [TW-1:0] tag);
    in_a = a; in_b = b; in_sub = sub; in_alu32 = alu32; in_sat = sat; in_tag = tag;
    in_valid = 1'b1;
  endtask

  task automatic run_op(input logic [W-1:0] a, b, input logic sub, alu32, sat,
                        input logic [TW-1:0] tag);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive_op(a, b, sub, alu32, sat, tag);
    @(posedge clk); #1;
    in_valid = 1'b0;
    r_lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        r_lat = i;
        break;
      end
    end
    r_res = out_result; r_c = out_carry; r_v = out_ovf; r_z = out_zero; r_n = out_neg;
    r_tag = out_tag;
  endtask

  // Tests
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_result !== '0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", out_result); end
    n_checks++; if ({out_carry, out_ovf, out_zero, out_neg} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {out_carry, out_ovf, out_zero, out_neg}); end
    n_checks++; if (out_tag !== '0) begin n_fail++; $display("FAIL reset_tag: got %h expected 0", out_tag); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_carry32();
    run_op(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0, 4'h1);
    n_checks++; if (r_lat !== LAT) begin n_fail++; $display("FAIL carry32_latency: got %0d expected %0d", r_lat, LAT); end
    n_checks++; if (r_res !== 64'h0000_0001_0000_0000) begin n_fail++; $display("FAIL carry32_result: got %h expected 0000000100000000", r_res); end
    n_checks++; if ({r_c, r_v, r_z, r_n} !== 4'b0000) begin n_fail++; $display("FAIL carry32_flags: got %b expected 0000", {r_c, r_v, r_z, r_n}); end
    n_checks++; if (r_tag !== 4'h1) begin n_fail++; $display("FAIL carry32_tag: got %h expected 1", r_tag); end
  endtask

  task automatic test_sub_neg();
    run_op(64'h0, 64'h1, 1'b1, 1'b0, 1'b0, 4'h2);
    n_checks++; if (r_lat !== LAT) begin n_fail++; $display("FAIL subneg_latency: got %0d expected %0d", r_lat, LAT); end
    n_checks++; if (r_res !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL subneg_result: got %h expected ffffffffffffffff", r_res); end
    n_checks++; if ({r_c, r_v, r_z, r_n} !== 4'b0001) begin n_fail++; $display("FAIL subneg_flags: got %b expected 0001", {r_c, r_v, r_z, r_n}); end
    run_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, 1'b0, 4'h3);
    n_checks++; if (r_res !== 64'h7FFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL subovf_result: got %h expected 7fffffffffffffff", r_res); end
    n_checks++; if ({r_c, r_v, r_z, r_n} !== 4'b1100) begin n_fail++; $display("FAIL subovf_flags: got %b expected 1100", {r_c, r_v, r_z, r_n}); end
  endtask

  task automatic test_alu32();
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1, 1'b0, 4'h4);
    n_checks++; if (r_lat !== LAT) begin n_fail++; $display("FAIL alu32wrap_latency: got %0d expected %0d", r_lat, LAT); end
    n_checks++; if (r_res !== 64'h0) begin n_fail++; $display("FAIL alu32wrap_result: got %h expected 0", r_res); end
    n_checks++; if ({r_c, r_v, r_z, r_n} !== 4'b1010) begin n_fail++; $display("FAIL alu32wrap_flags: got %b expected 1010", {r_c, r_v, r_z, r_n}); end
    run_op(64'hAAAA_AAAA_0000_0005, 64'h5555_5555_0000_0007, 1'b1, 1'b1, 1'b0, 4'h5);
    n_checks++; if (r_res !== 64'h0000_0000_FFFF_FFFE) begin n_fail++; $display("FAIL alu32sub_result: got %h expected 00000000fffffffe", r_res); end
    n_checks++; if ({r_c, r_v, r_z, r_n} !== 4'b0001) begin n_fail++; $display("FAIL alu32sub_flags: got %b expected 0001", {r_c, r_v, r_z, r_n}); end
    run_op(64'h1234_5678_8000_0000, 64'h0000_0001_8000_0000, 1'b0, 1'b1, 1'b0, 4'h6);
    n_checks++; if (r_res !== 64'h0) begin n_fail++; $display("FAIL alu32ovf_result: got %h expected 0", r_res); end
    n_checks++; if ({r_c, r_v, r_z, r_n} !== 4'b1110) begin n_fail++; $display("FAIL alu32ovf_flags: got %b expected 1110", {r_c, r_v, r_z, r_n}); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] exp_pos, exp_neg, exp_32;
`ifdef ADDSUB_SAT_EN
    exp_pos = 64'h7FFF_FFFF_FFFF_FFFF;
    exp_neg = 64'h8000_0000_0000_0000;
    exp_32  = 64'h0000_0000_7FFF_FFFF;
`else
    exp_pos = 64'h8000_0000_0000_0000;
    exp_neg = 64'h7FFF_FFFF_FFFF_FFFF;
    exp_32  = 64'h0000_0000_8000_0000;
`endif
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b1, 4'h7);
    n_checks++; if (r_res !== exp_pos) begin n_fail++; $display("FAIL ovfpos_result: got %h expected %h", r_res, exp_pos); end
    n_checks++; if (r_v !== 1'b1) begin n_fail++; $display("FAIL ovfpos_ovf: got %b expected 1", r_v); end
    n_checks++; if (r_c !== 1'b0) begin n_fail++; $display("FAIL ovfpos_carry: got %b expected 0", r_c); end
    run_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 4'h8);
    n_checks++; if (r_res !== exp_neg) begin n_fail++; $display("FAIL ovfneg_result: got %h expected %h", r_res, exp_neg); end
    n_checks++; if ({r_c, r_v} !== 2'b11) begin n_fail++; $display("FAIL ovfneg_cv: got %b expected 11", {r_c, r_v}); end
    run_op(64'h0000_0000_7FFF_FFFF, 64'h1, 1'b0, 1'b1, 1'b1, 4'h9);
    n_checks++; if (r_res !== exp_32) begin n_fail++; $display("FAIL ovf32_result: got %h expected %h", r_res, exp_32); end
    n_checks++; if (r_v !== 1'b1) begin n_fail++; $display("FAIL ovf32_ovf: got %b expected 1", r_v); end
  endtask

  task automatic test_backpressure();
    int            received = 0;
    logic [7:0]    seen = '0;
    logic          stalled = 1'b0;
    logic [W-1:0]  held_res = '0;
    logic [TW-1:0] held_tag = '0;
    logic [W+TW:0] exp;
    exp_q.delete();
    fork
      begin : drv
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
          logic [W-1:0] a, b;
          logic s, m, hs;
          a = {$urandom, $urandom};
          b = {$urandom, $urandom};
          s = 1'($urandom_range(0, 1));
          m = 1'($urandom_range(0, 1));
          hs = 1'b0;
          drive_op(a, b, s, m, 1'b0, 4'(i));
          for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
              hs = 1'b1;
              break;
            end
          end
          n_checks++; if (hs !== 1'b1) begin n_fail++; $display("FAIL bp_accept: op %0d got no handshake expected one", i); end
          exp_q.push_back(model(a, b, s, m, 4'(i)));
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin : rcv
        for (int cyc = 0; cyc < 600 && received < 8; cyc++) begin
          @(posedge clk); #1;
          if (stalled) begin
            n_checks++; if (out_valid !== 1'b1 || out_result !== held_res || out_tag !== held_tag) begin
              n_fail++; $display("FAIL bp_stable: got v=%b %h/%h expected v=1 %h/%h", out_valid, out_result, out_tag, held_res, held_tag);
            end
            stalled = 1'b0;
          end
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid) begin
            if (out_ready) begin
              n_checks++;
              if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL bp_order: got tag %h expected no output", out_tag);
              end else begin
                exp = exp_q.pop_front();
                if ({out_tag, out_carry, out_result} !== exp) begin
                  n_fail++; $display("FAIL bp_result: got %h expected %h", {out_tag, out_carry, out_result}, exp);
                end
              end
              seen[out_tag[2:0]] = 1'b1;
              received++;
            end else begin
              stalled  = 1'b1;
              held_res = out_result;
              held_tag = out_tag;
            end
          end
        end
        out_ready = 1'b1;
      end
    join
    n_checks++; if (received !== 8) begin n_fail++; $display("FAIL bp_count: got %0d expected 8", received); end
    n_checks++; if (seen !== 8'hFF) begin n_fail++; $display("FAIL bp_tags: got %b expected 11111111", seen); end
  endtask

  task automatic test_reset_midflight();
    int w = 0;
    int stale = 0;
    out_ready = 1'b1;
    @(posedge clk); #1; drive_op(64'h11, 64'h22, 1'b0, 1'b0, 1'b0, 4'hA);
    @(posedge clk); #1; drive_op(64'h33, 64'h44, 1'b0, 1'b0, 1'b0, 4'hB);
    @(posedge clk); #1; drive_op(64'h55, 64'h66, 1'b0, 1'b0, 1'b0, 4'hC);
    @(posedge clk); #1; in_valid = 1'b0; out_ready = 1'b0;
    while (!out_valid && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_fill: got %b expected 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_result !== '0 || out_tag !== '0) begin n_fail++; $display("FAIL rst_async_data: got %h/%h expected 0/0", out_result, out_tag); end
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    n_checks++; if (stale !== 0) begin n_fail++; $display("FAIL rst_stale: got %0d valid cycles expected 0", stale); end
    run_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 1'b0, 4'hD);
    n_checks++; if (r_lat !== LAT) begin n_fail++; $display("FAIL rst_next_latency: got %0d expected %0d", r_lat, LAT); end
    n_checks++; if (r_res !== 64'h1234_5678_9ABC_DF00) begin n_fail++; $display("FAIL rst_next_result: got %h expected 123456789abcdf00", r_res); end
    n_checks++; if (r_tag !== 4'hD) begin n_fail++; $display("FAIL rst_next_tag: got %h expected d", r_tag); end
  endtask

  initial begin
    test_reset();
    test_carry32();
    test_sub_neg();
    test_alu32();
    test_overflow();
    test_backpressure();
    test_reset_midflight();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
